// File: rtl/icetap_capture_seq.sv
// icetap_capture_seq: capture core with circular sample RAM, pre-trigger
// window and a multi-stage trigger sequencer with per-stage occurrence counts.
// Optional build macro ICETAP_STORE_QUAL_EN adds a storage qualifier
// (store_mode_vec) so that only matching samples are written.
module icetap_capture_seq #(
    parameter int NR_SIGNALS   = 4,
    parameter int RECORD_DEPTH = 16,
    parameter int NR_STAGES    = 2,
    parameter int CNT_BITS     = 8,
    localparam int ADDR_BITS   = $clog2(RECORD_DEPTH),
    localparam int STG_BITS    = $clog2(NR_STAGES + 1)
) (
    input  logic                             src_clk,
    input  logic                             src_reset,
    input  logic [NR_SIGNALS-1:0]            signals_in,
    input  logic [NR_STAGES*NR_SIGNALS*2-1:0] trig_mode_vec,
    input  logic [NR_STAGES*CNT_BITS-1:0]    trig_count_vec,
    input  logic [STG_BITS-1:0]              stages_used,
    input  logic [ADDR_BITS-1:0]             pre_trigger,
    input  logic                             start,
    input  logic                             abort,
`ifdef ICETAP_STORE_QUAL_EN
    input  logic [NR_SIGNALS*2-1:0]          store_mode_vec,
`endif
    output logic [2:0]                       state,
    output logic [STG_BITS-1:0]              cur_stage,
    output logic [ADDR_BITS-1:0]             start_addr,
    output logic [ADDR_BITS-1:0]             trigger_addr,
    output logic [ADDR_BITS-1:0]             stop_addr,
    input  logic                             rd_en,
    input  logic [ADDR_BITS-1:0]             rd_addr,
    output logic [NR_SIGNALS-1:0]            rd_data,
    output logic                             rd_valid
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(RECORD_DEPTH - 1);
    localparam logic [STG_BITS-1:0]  STG_ONE   = STG_BITS'(1);
    localparam logic [CNT_BITS-1:0]  CNT_ONE   = CNT_BITS'(1);

    logic [NR_SIGNALS-1:0] s1;
    logic [NR_SIGNALS-1:0] s2;
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [ADDR_BITS-1:0]  fill_cnt;
    logic [ADDR_BITS-1:0]  post_cnt;
    logic [ADDR_BITS-1:0]  pre_lat;
    logic [CNT_BITS-1:0]   occ;

    logic                  stage_hit;
    logic [CNT_BITS-1:0]   stage_cnt;
    logic                  store_ok;
    logic                  trig_now;
    logic                  wr_en;
    logic [ADDR_BITS-1:0]  post_total;

    logic [NR_SIGNALS-1:0] mem [RECORD_DEPTH];

    // Per-signal condition check shared by trigger stages and the store qualifier
    function automatic logic cond_match(input logic [NR_SIGNALS*2-1:0] modes,
                                        input logic [NR_SIGNALS-1:0]   cur,
                                        input logic [NR_SIGNALS-1:0]   prev);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NR_SIGNALS; i++) begin
            case (modes[2*i +: 2])
                2'b01:   if (!cur[i]) ok = 1'b0;
                2'b10:   if (cur[i]) ok = 1'b0;
                2'b11:   if (cur[i] == prev[i]) ok = 1'b0;
                default: ;
            endcase
        end
        return ok;
    endfunction

    // Two-deep input pipeline: s1 is the sample, s2 its predecessor for edge detection
    always_ff @(posedge src_clk) begin
        if (src_reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= signals_in;
            s2 <= s1;
        end
    end

    // Select the condition and occurrence count of the active sequencer stage
    always_comb begin
        stage_hit = 1'b0;
        stage_cnt = '0;
        for (int k = 0; k < NR_STAGES; k++) begin
            if (STG_BITS'(k) == cur_stage) begin
                stage_hit = cond_match(trig_mode_vec[k*NR_SIGNALS*2 +: NR_SIGNALS*2], s1, s2);
                stage_cnt = trig_count_vec[k*CNT_BITS +: CNT_BITS];
            end
        end
    end

    // Trigger decision, storage qualification and RAM write enable for this cycle
    always_comb begin
`ifdef ICETAP_STORE_QUAL_EN
        store_ok = cond_match(store_mode_vec, s1, s2);
`else
        store_ok = 1'b1;
`endif
        trig_now = (state == ST_ARMED) &&
                   ((stages_used == '0) ||
                    (stage_hit && (occ == stage_cnt) && (cur_stage == stages_used - STG_ONE)));
        wr_en = !src_reset && !abort &&
                ((((state == ST_FILL) || (state == ST_POST)) && store_ok) ||
                 ((state == ST_ARMED) && (store_ok || trig_now)));
        post_total = ADDR_LAST - pre_lat;
    end

    // Capture control: start/abort handling, fill, trigger sequencing and post-trigger count
    always_ff @(posedge src_clk) begin
        if (src_reset) begin
            state        <= ST_IDLE;
            cur_stage    <= '0;
            start_addr   <= '0;
            trigger_addr <= '0;
            stop_addr    <= '0;
            wr_addr      <= '0;
            fill_cnt     <= '0;
            post_cnt     <= '0;
            pre_lat      <= '0;
            occ          <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        wr_addr   <= '0;
                        fill_cnt  <= '0;
                        post_cnt  <= '0;
                        cur_stage <= '0;
                        occ       <= '0;
                        // The port width already caps pre_trigger at RECORD_DEPTH-1
                        pre_lat   <= pre_trigger;
                        state     <= (pre_trigger != '0) ? ST_FILL : ST_ARMED;
                    end
                end
                ST_FILL: begin
                    if (store_ok) begin
                        wr_addr  <= wr_addr + ADDR_ONE;
                        fill_cnt <= fill_cnt + ADDR_ONE;
                        if (fill_cnt == pre_lat - ADDR_ONE) state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (wr_en) wr_addr <= wr_addr + ADDR_ONE;
                    if ((stages_used != '0) && stage_hit) begin
                        if (occ == stage_cnt) begin
                            occ       <= '0;
                            cur_stage <= cur_stage + STG_ONE;
                        end else begin
                            occ <= occ + CNT_ONE;
                        end
                    end
                    if (trig_now) begin
                        trigger_addr <= wr_addr;
                        start_addr   <= wr_addr - pre_lat;
                        post_cnt     <= '0;
                        if (post_total == '0) begin
                            stop_addr <= wr_addr;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (store_ok) begin
                        wr_addr  <= wr_addr + ADDR_ONE;
                        post_cnt <= post_cnt + ADDR_ONE;
                        if (post_cnt == post_total - ADDR_ONE) begin
                            stop_addr <= wr_addr;
                            state     <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sample RAM write port
    always_ff @(posedge src_clk) begin
        if (wr_en) mem[wr_addr] <= s1;
    end

    // Registered read port; a same-address write in this cycle returns the old word
    always_ff @(posedge src_clk) begin
        if (src_reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_icetap_capture_seq.sv
// Testbench for icetap_capture_seq: directed and randomized captures checked
// against a sample-list reference model; also reset, abort and start-ignore cases.
module tb_icetap_capture_seq;

    localparam int NS    = 4;
    localparam int DEPTH = 16;
    localparam int NST   = 2;
    localparam int CB    = 8;
    localparam int N     = 64;

    logic        src_clk = 1'b0;
    logic        src_reset;
    logic [3:0]  signals_in;
    logic [15:0] trig_mode_vec;
    logic [15:0] trig_count_vec;
    logic [1:0]  stages_used;
    logic [3:0]  pre_trigger;
    logic        start;
    logic        abort;
    logic [7:0]  store_mode_vec;
    logic [2:0]  state;
    logic [1:0]  cur_stage;
    logic [3:0]  start_addr;
    logic [3:0]  trigger_addr;
    logic [3:0]  stop_addr;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [3:0]  rd_data;
    logic        rd_valid;

    int total = 0;
    int bad   = 0;

    // Configuration as seen by the reference model
    logic [7:0] stage_mode [NST];
    logic [7:0] stage_cnt  [NST];
    logic [7:0] store_mode;
    int         su;
    int         pre;
    logic [3:0] idle_val;
    logic [3:0] stim [N];

    // Model results
    logic [2:0] exp_state [N+1];
    int         exp_cur   [N+1];
    bit         exp_done;
    int         exp_ta, exp_sa, exp_pa;
    logic [3:0] exp_ram [DEPTH];

    icetap_capture_seq #(
        .NR_SIGNALS(NS), .RECORD_DEPTH(DEPTH), .NR_STAGES(NST), .CNT_BITS(CB)
    ) dut (
        .src_clk(src_clk),
        .src_reset(src_reset),
        .signals_in(signals_in),
        .trig_mode_vec(trig_mode_vec),
        .trig_count_vec(trig_count_vec),
        .stages_used(stages_used),
        .pre_trigger(pre_trigger),
        .start(start),
        .abort(abort),
`ifdef ICETAP_STORE_QUAL_EN
        .store_mode_vec(store_mode_vec),
`endif
        .state(state),
        .cur_stage(cur_stage),
        .start_addr(start_addr),
        .trigger_addr(trigger_addr),
        .stop_addr(stop_addr),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid)
    );

    always #5 src_clk = ~src_clk;

    // Hard stop in case something wedges the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge src_clk);
        #1;
    endtask

    task automatic apply_config();
        trig_mode_vec  = {stage_mode[1], stage_mode[0]};
        trig_count_vec = {stage_cnt[1], stage_cnt[0]};
        stages_used    = 2'(su);
        pre_trigger    = 4'(pre);
        store_mode_vec = store_mode;
    endtask

    task automatic clear_config();
        for (int k = 0; k < NST; k++) begin
            stage_mode[k] = 8'h00;
            stage_cnt[k]  = 8'h00;
        end
        store_mode = 8'h00;
        idle_val   = 4'h0;
    endtask

    function automatic bit cond_ok(logic [7:0] m, logic [3:0] v, logic [3:0] p);
        for (int i = 0; i < NS; i++) begin
            logic [1:0] md;
            md = m[2*i +: 2];
            if (md == 2'b01 && v[i] !== 1'b1) return 1'b0;
            if (md == 2'b10 && v[i] !== 1'b0) return 1'b0;
            if (md == 2'b11 && v[i] === p[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: walk the sample stream, collect written samples in order,
    // locate the trigger and the end of the window, then derive state per cycle.
    task automatic model_capture();
        logic [3:0] wq[$];
        logic [3:0] prev;
        int arm_n, t_n, last_n, t_w, cur, occ;
        bit stored, is_trig;
        wq.delete();
        arm_n = (pre == 0) ? 0 : -1;
        t_n = -1; last_n = -1; t_w = 0; cur = 0; occ = 0;
        exp_cur[0] = 0;
        for (int n = 0; n < N; n++) begin
            prev   = (n == 0) ? idle_val : stim[n-1];
            stored = cond_ok(store_mode, stim[n], prev);
            if (arm_n < 0) begin
                if (stored) begin
                    wq.push_back(stim[n]);
                    if (int'(wq.size()) == pre) arm_n = n + 1;
                end
            end else if (t_n < 0) begin
                is_trig = 1'b0;
                if (su == 0) is_trig = 1'b1;
                else if (cur < NST && cond_ok(stage_mode[cur], stim[n], prev)) begin
                    if (occ == int'(stage_cnt[cur])) begin
                        occ = 0;
                        if (cur == su - 1) is_trig = 1'b1;
                        cur++;
                    end else occ++;
                end
                if (stored || is_trig) wq.push_back(stim[n]);
                if (is_trig) begin
                    t_n = n;
                    t_w = int'(wq.size()) - 1;
                    if (pre == DEPTH - 1) last_n = n;
                end
            end else if (last_n < 0) begin
                if (stored) begin
                    wq.push_back(stim[n]);
                    if (int'(wq.size()) - 1 - t_w == DEPTH - 1 - pre) last_n = n;
                end
            end
            exp_cur[n+1] = cur;
        end
        for (int j = 0; j <= N; j++) begin
            if (arm_n < 0 || j < arm_n)        exp_state[j] = 3'd1;
            else if (t_n < 0 || j <= t_n)      exp_state[j] = 3'd2;
            else if (last_n < 0 || j <= last_n) exp_state[j] = 3'd3;
            else                               exp_state[j] = 3'd4;
        end
        exp_done = (last_n >= 0);
        if (exp_done) begin
            exp_ta = t_w % DEPTH;
            exp_sa = (t_w - pre) % DEPTH;
            exp_pa = (int'(wq.size()) - 1) % DEPTH;
            for (int k = int'(wq.size()) - DEPTH; k < int'(wq.size()); k++)
                exp_ram[k % DEPTH] = wq[k];
        end
    endtask

    task automatic build_scenario(input int sc);
        clear_config();
        case (sc)
            0: begin
                su = 0; pre = 4;
                for (int n = 0; n < N; n++) stim[n] = 4'(n);
            end
            1: begin
                su = 1; pre = 4; stage_mode[0] = 8'h01;
                for (int n = 0; n < N; n++) stim[n] = {3'($urandom), (n >= 24)};
            end
            2: begin
                su = 2; pre = 4; idle_val = 4'b0100;
                stage_mode[0] = 8'h0C; stage_cnt[0] = 8'd2;
                stage_mode[1] = 8'h20; stage_cnt[1] = 8'd0;
                for (int n = 0; n < N; n++) begin
                    stim[n][0] = 1'($urandom);
                    stim[n][3] = 1'($urandom);
                    stim[n][1] = ((n >= 8 && n < 11) || n >= 14);
                    stim[n][2] = !(n == 6 || n >= 18);
                end
            end
            3: begin
                su = 1; pre = 15; stage_mode[0] = 8'h40; stage_cnt[0] = 8'd1;
                for (int n = 0; n < N; n++) stim[n] = 4'($urandom);
                stim[20][3] = 1'b1; stim[21][3] = 1'b1;
            end
            4: begin
                su = 0; pre = 0;
                for (int n = 0; n < N; n++) stim[n] = 4'($urandom);
            end
            11: begin
                su = 0; pre = 4; store_mode = 8'h40;
                for (int n = 0; n < N; n++) stim[n] = {(n % 2 == 0), 3'(n / 2)};
            end
            default: begin
                su = int'($urandom_range(0, 2));
                pre = int'($urandom_range(0, 15));
                for (int k = 0; k < NST; k++) begin
                    for (int i = 0; i < NS; i++)
                        stage_mode[k][2*i +: 2] = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom);
                    stage_cnt[k] = 8'($urandom_range(0, 3));
                end
                idle_val = 4'($urandom);
                for (int n = 0; n < N; n++) stim[n] = 4'($urandom);
            end
        endcase
    endtask

    task automatic start_capture(input int s, input int p, input logic [7:0] m0);
        clear_config();
        su = s; pre = p; stage_mode[0] = m0;
        apply_config();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_for_state(input logic [2:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (state === target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        src_reset = 1'b1; signals_in = '0; start = 1'b0; abort = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        clear_config(); su = 0; pre = 0; apply_config();
        tick(); tick(); tick();
        src_reset = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
        total++; if (cur_stage !== 2'd0) begin bad++; $display("[TB] FAIL reset_stage: got %0d want 0", cur_stage); end
        total++; if ({start_addr, trigger_addr, stop_addr} !== 12'h000) begin
            bad++; $display("[TB] FAIL reset_addrs: got %0d/%0d/%0d want 0/0/0", start_addr, trigger_addr, stop_addr);
        end
        total++; if (rd_valid !== 1'b0 || rd_data !== 4'h0) begin
            bad++; $display("[TB] FAIL reset_read: got valid=%0b data=%0h want 0/0", rd_valid, rd_data);
        end
        tick();
    endtask

    task automatic test_capture_windows();
        int nsc;
`ifdef ICETAP_STORE_QUAL_EN
        nsc = 12;
`else
        nsc = 11;
`endif
        for (int sc = 0; sc < nsc; sc++) begin
            build_scenario(sc);
            apply_config();
            model_capture();
            signals_in = idle_val;
            tick(); tick();
            signals_in = stim[0];
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int j = 0; j <= N; j++) begin
                total++;
                if (state !== exp_state[j]) begin
                    bad++; $display("[TB] FAIL sc%0d state@%0d: got %0d want %0d", sc, j, state, exp_state[j]);
                end
                total++;
                if (cur_stage !== 2'(exp_cur[j])) begin
                    bad++; $display("[TB] FAIL sc%0d cur_stage@%0d: got %0d want %0d", sc, j, cur_stage, exp_cur[j]);
                end
                if (exp_state[j] == 3'd4 || j == N) break;
                signals_in = (j + 1 < N) ? stim[j+1] : idle_val;
                tick();
            end
            signals_in = idle_val;
            if (!exp_done) begin
                abort = 1'b1; tick(); abort = 1'b0;
                total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL sc%0d abort_idle: got %0d want 0", sc, state); end
                continue;
            end
            total++;
            if (int'(trigger_addr) != exp_ta || int'(start_addr) != exp_sa || int'(stop_addr) != exp_pa) begin
                bad++; $display("[TB] FAIL sc%0d window: got s=%0d t=%0d p=%0d want s=%0d t=%0d p=%0d",
                                sc, start_addr, trigger_addr, stop_addr, exp_sa, exp_ta, exp_pa);
            end
            if (sc == 0 || sc == 1) begin
                total++;
                if ({start_addr, trigger_addr, stop_addr} !== ((sc == 0) ? {4'd0, 4'd4, 4'd15} : {4'd4, 4'd8, 4'd3})) begin
                    bad++; $display("[TB] FAIL sc%0d fixed_window: got s=%0d t=%0d p=%0d", sc, start_addr, trigger_addr, stop_addr);
                end
            end
            for (int a = 0; a < DEPTH; a++) begin
                rd_en = 1'b1; rd_addr = 4'(a);
                tick();
                total++;
                if (rd_valid !== 1'b1 || rd_data !== exp_ram[a]) begin
                    bad++; $display("[TB] FAIL sc%0d ram[%0d]: got v=%0b d=%0h want v=1 d=%0h", sc, a, rd_valid, rd_data, exp_ram[a]);
                end
            end
            rd_en = 1'b0;
            tick();
            total++;
            if (rd_valid !== 1'b0 || rd_data !== exp_ram[DEPTH-1]) begin
                bad++; $display("[TB] FAIL sc%0d rd_idle: got v=%0b d=%0h want v=0 d=%0h", sc, rd_valid, rd_data, exp_ram[DEPTH-1]);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        signals_in = 4'h0;
        start_capture(0, 4, 8'h00);
        repeat (5) tick();
        total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL abort_pre_post: got %0d want 3", state); end
        abort = 1'b1; tick(); abort = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL abort_in_post: got %0d want 0", state); end
        total++; if (trigger_addr !== 4'd4 || start_addr !== 4'd0) begin
            bad++; $display("[TB] FAIL abort_hold: got t=%0d s=%0d want t=4 s=0", trigger_addr, start_addr);
        end
        start_capture(0, 4, 8'h00);
        wait_for_state(3'd4, 40, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL abort_reach_done: got %0d want 4", state); end
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL start_abort_same: got %0d want 0", state); end
    endtask

    task automatic test_start_ignored();
        signals_in = 4'h0;
        start_capture(1, 4, 8'h01);
        repeat (5) tick();
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL ign_armed: got %0d want 2", state); end
        start = 1'b1; tick(); start = 1'b0;
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL ign_start: got %0d want 2", state); end
        tick(); tick();
        total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL ign_still_armed: got %0d want 2", state); end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_reset_mid_armed();
        bit ok;
        for (int n = 0; n < 4; n++) begin signals_in = 4'(n); tick(); end
        signals_in = 4'h0;
        start_capture(0, 4, 8'h00);
        for (int n = 1; n < 20; n++) begin signals_in = 4'(n); tick(); end
        wait_for_state(3'd4, 20, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL rst_setup_done: got %0d want 4", state); end
        rd_en = 1'b1; rd_addr = 4'd5;
        signals_in = 4'h0;
        start_capture(1, 0, 8'h01);
        tick(); tick();
        total++; if (state !== 3'd2 || rd_valid !== 1'b1 || trigger_addr !== 4'd4) begin
            bad++; $display("[TB] FAIL rst_pre_armed: got st=%0d v=%0b t=%0d want 2/1/4", state, rd_valid, trigger_addr);
        end
        rd_en = 1'b0;
        src_reset = 1'b1; tick(); src_reset = 1'b0;
        total++;
        if (state !== 3'd0 || cur_stage !== 2'd0 || {start_addr, trigger_addr, stop_addr} !== 12'h000 ||
            rd_valid !== 1'b0 || rd_data !== 4'h0) begin
            bad++; $display("[TB] FAIL rst_mid_armed: got st=%0d cs=%0d s=%0d t=%0d p=%0d v=%0b d=%0h want all 0",
                            state, cur_stage, start_addr, trigger_addr, stop_addr, rd_valid, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_capture_windows();
        test_abort();
        test_start_ignored();
        test_reset_mid_armed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icetap_capture_seq.md
Name: icetap_capture_seq

Overview:
- Next-generation capture core for icetap.
- Records NR_SIGNALS probe signals into an internal circular sample RAM.
- Configurable pre-trigger depth and a multi-stage trigger sequencer with per-stage occurrence counts.
- Sits in the src_clk domain. Configuration comes from the scan/JTAG register layer, which also reads back status and samples through a synchronous read port.

Parameters:
- NR_SIGNALS, 4: probe width.
- RECORD_DEPTH, 16: sample RAM depth. Must be a power of 2, >=4. ADDR_BITS = $clog2(RECORD_DEPTH).
- NR_STAGES, 2: trigger sequencer stages, >=1. STG_BITS = $clog2(NR_STAGES+1).
- CNT_BITS, 8: width of each per-stage occurrence count.

Ports:
- src_clk  in  1  sample clock.
- src_reset  in  1  synchronous, active-high reset.
- signals_in  in  NR_SIGNALS  probed signals.
- trig_mode_vec  in  NR_STAGES*NR_SIGNALS*2  per stage, per signal condition: 00 don't care, 01 high, 10 low, 11 any edge.
- trig_count_vec  in  NR_STAGES*CNT_BITS  per stage: stage completes on match number (value+1).
- stages_used  in  STG_BITS  number of active stages. 0 = trigger immediately on arming.
- pre_trigger  in  ADDR_BITS  samples retained before the trigger sample.
- start  in  1  pulse: begin capture.
- abort  in  1  pulse: stop capture.
- state  out  3  0 IDLE, 1 FILL, 2 ARMED, 3 POST, 4 DONE.
- cur_stage  out  STG_BITS  active sequencer stage.
- start_addr, trigger_addr, stop_addr  out  ADDR_BITS each  capture window.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_BITS  read address.
- rd_data  out  NR_SIGNALS  read sample.
- rd_valid  out  1  rd_data valid.

Behaviour:
- Reset:
  - state=IDLE; cur_stage=0; all addresses 0; rd_valid=0; rd_data=0.
  - Internal counters cleared.
  - Reset mid-capture abandons the capture immediately.
- Input pipeline:
  - s1 <= signals_in; s2 <= s1.
  - Written sample is s1.
  - Edge condition: s1 != s2.
  - A stage matches when every non-don't-care signal satisfies its mode.
  - Match is evaluated on the same s1 being written this cycle.
- start:
  - Accepted only in IDLE or DONE; ignored otherwise.
  - Clears wr_addr, fill count, cur_stage and occurrence count.
  - Next state is FILL if the effective pre-trigger is >0, else ARMED.
  - Effective pre-trigger = min(pre_trigger, RECORD_DEPTH-1).
- abort: any state -> IDLE next cycle. Address outputs hold. Same-cycle start+abort: abort wins.
- FILL:
  - Write s1 at wr_addr each cycle; wr_addr++.
  - Trigger is not evaluated.
  - After the effective pre-trigger count of writes -> ARMED.
- ARMED:
  - Write each cycle; wr_addr wraps mod RECORD_DEPTH.
  - On a match in cur_stage: occ++. When occ==count of that stage, occ<=0 and cur_stage++.
  - Completion of stage stages_used-1 is the trigger sample (stages_used=0: first ARMED sample). On the trigger sample:
    - trigger_addr <= its wr_addr.
    - start_addr <= trigger_addr - pre (mod RECORD_DEPTH).
    - state <= POST.
- POST:
  - Write RECORD_DEPTH-1-pre further samples, then stop_addr <= last written address and state <= DONE.
  - If that count is 0: DONE next cycle with stop_addr=trigger_addr.
- DONE: no writes. Outputs hold until start or reset.
- Read port:
  - rd_en -> rd_data = RAM[rd_addr] with rd_valid=1 exactly one cycle later.
  - rd_data holds otherwise; rd_valid=0 otherwise.
  - Reads are legal in any state; contents are defined only in DONE.
- Inferred single RAM: 1 write port, 1 read port, same clock. Read-during-write to the same address returns old data.

Optional Feature:
- Macro: ICETAP_STORE_QUAL_EN.
- When defined:
  - Extra input store_mode_vec [NR_SIGNALS*2] (same encoding as trig_mode_vec).
  - In FILL/ARMED/POST, only matching samples are written and counted.
  - The trigger sample is always written.
  - Trigger evaluation still sees every cycle.
  - All-don't-care behaves as no qualifier.
- When undefined: port absent; every cycle is stored.

Test Plan:
- Config NR_SIGNALS=4, RECORD_DEPTH=16, NR_STAGES=2, stages_used=0, pre=4, start pulse -> FILL 4 cycles, ARMED 1 cycle, POST 11 cycles, DONE; start_addr=0, trigger_addr=4, stop_addr=15; readback equals the applied ramp.
- Same config with stages_used=1, stage0 = sig0 high, count 0, sig0 rising on ARMED cycle 20 -> trigger_addr=8, start_addr=4, stop_addr=3 (wrap).
- stages_used=2, stage0 = sig1 edge count 2, stage1 = sig2 low count 0; toggle sig1 three times, then drive sig2 low -> cur_stage 0->1 after the 3rd edge; trigger on the first sig2-low sample; no trigger if sig2 goes low before that.
- pre_trigger=15 -> trigger -> DONE next cycle with stop_addr=trigger_addr; pre_trigger=0 -> FILL skipped.
- abort in POST -> IDLE. start+abort same cycle in DONE -> IDLE. src_reset mid-ARMED -> all outputs 0. start during ARMED -> ignored.
- ICETAP_STORE_QUAL_EN, store sig3 high, sig3 high every 2nd cycle -> only sig3-high samples in the RAM, and window timing doubles.
